// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM that sequences the edge counter,
// data sampler and bit checkers, and reports one result pulse per frame.
//
// Ports:
//   clk, rst        clock (prescale x bit rate), async active-low reset
//   rx_in           synchronized serial line, idle high
//   par_en          frame carries a parity bit (latched per frame)
//   prescale        oversampling ratio (8, 16 or 32)
//   edge_cnt        oversample edge count, wraps at prescale-1
//   strt_glitch,
//   par_err,
//   stp_err         checker results, valid after the matching check strobe
//   edge_cnt_en,
//   dat_samp_en     enables, high in every state except IDLE
//   strt_chk_en,
//   deser_en,
//   par_chk_en,
//   stp_chk_en      single-cycle action strobes at the sample point
//   data_valid,
//   par_err_o,
//   frame_err       frame result, visible in the first IDLE cycle only
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_cnt_en,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_o,
    output logic       frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bit_idx;
    logic       par_lat;
    logic       par_flag;

    logic [5:0] edge6;
    logic       bit_end;
    logic       samp_done;
    logic       frame_go;

    assign edge6     = {1'b0, edge_cnt};
    assign bit_end   = (edge6 == (prescale - 6'd1));
    // Sample point sits two edges past mid-bit.
    assign samp_done = (edge6 == ((prescale >> 1) + 6'd2));
    assign frame_go  = (state == IDLE) && !rx_in;

    assign edge_cnt_en = (state != IDLE);
    assign dat_samp_en = (state != IDLE);

    assign strt_chk_en = (state == START)  && samp_done;
    assign deser_en    = (state == DATA)   && samp_done;
    assign par_chk_en  = (state == PARITY) && samp_done;
    assign stp_chk_en  = (state == STOP)   && samp_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx_in)
                    state_nxt = START;
            end
            START: begin
                if (bit_end)
                    state_nxt = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx == LAST_BIT))
                    state_nxt = par_lat ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end)
                    state_nxt = STOP;
            end
            STOP: begin
                if (bit_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            par_lat    <= 1'b0;
            par_flag   <= 1'b0;
            data_valid <= 1'b0;
            par_err_o  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= 1'b0;
            par_err_o  <= 1'b0;
            frame_err  <= 1'b0;

            // par_en is sampled once so a mid-frame change is ignored.
            if (frame_go) begin
                par_lat  <= par_en;
                par_flag <= 1'b0;
            end

            if ((state == START) && bit_end)
                bit_idx <= 3'd0;

            if ((state == DATA) && bit_end)
                bit_idx <= bit_idx + 3'd1;

            if ((state == PARITY) && bit_end)
                par_flag <= par_flag | par_err;

            // Result registers so it lands in the first IDLE cycle.
            if ((state == STOP) && bit_end) begin
                data_valid <= !stp_err && !par_flag;
                par_err_o  <= par_flag;
                frame_err  <= stp_err;
            end
        end
    end

endmodule
